// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical memory port between the instruction
// fetch requester (A, read-only) and the data requester (B, read/write).
// Data requests win ties until B has taken MAX_D_STREAK grants in a row while
// A waited, then A is forced through so fetch always makes progress.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // Instruction-fetch side
  input  logic                    read_a,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  output logic                    resp_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  // Data side
  input  logic                    read_b,
  input  logic                    write_b,
  input  logic [DATA_WIDTH/8-1:0] wmask_b,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic                    resp_b,
  output logic [DATA_WIDTH-1:0]   rdata_b,
  // Physical memory side
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // The streak counter only needs to reach MAX_D_STREAK, where it saturates.
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  state_t              r_state;
  logic [STREAK_W-1:0] r_streak;

  logic w_a_pend;
  logic w_b_pend;
  logic w_grant_a;
  logic w_grant_b;

  // Grant decision: B wins unless A is also waiting and B has used up its streak.
  always_comb begin
    w_a_pend  = read_a;
    w_b_pend  = read_b | write_b;
    w_grant_b = 1'b0;
    w_grant_a = 1'b0;
    if (r_state == IDLE) begin
      w_grant_b = w_b_pend && (!w_a_pend || (r_streak < STREAK_MAX));
      w_grant_a = w_a_pend && !w_grant_b;
    end
  end

  // Arbiter FSM: captures the granted request into the registered memory
  // outputs and holds them until the memory completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wmask   <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_b) begin
            // A simultaneous read and write on B resolves to the write.
            pmem_read    <= ~write_b;
            pmem_write   <= write_b;
            pmem_wmask   <= write_b ? wmask_b : '0;
            pmem_wdata   <= write_b ? wdata_b : '0;
            pmem_address <= address_b;
            r_state      <= SERVE_B;
            if (!w_a_pend) begin
              r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
              r_streak <= r_streak + STREAK_ONE;
            end
          end else if (w_grant_a) begin
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_wmask   <= '0;
            pmem_wdata   <= '0;
            pmem_address <= address_a;
            r_state      <= SERVE_A;
            r_streak     <= '0;
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            r_state    <= RECOVER;
          end
        end
        RECOVER: begin
          // One dead cycle so the satisfied requester can drop its request.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Completion strobes and read data are steered straight from the memory in
  // the response cycle; data buses stay at zero otherwise.
  always_comb begin
    resp_a  = (r_state == SERVE_A) && pmem_resp;
    resp_b  = (r_state == SERVE_B) && pmem_resp;
    rdata_a = resp_a ? pmem_rdata : '0;
    rdata_b = resp_b ? pmem_rdata : '0;
    busy    = (r_state != IDLE);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one physical memory port between the pipeline's instruction-fetch requester (port A, read-only) and data-memory requester (port B, read/write). It replaces the two independent memory interfaces the CPU datapath drives today. Each request is captured into registered memory-side outputs at grant and held until the memory returns pmem_resp. Data-side requests have priority, bounded by a starvation limit so instruction fetch always makes progress.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of read and write data buses
MAX_D_STREAK, 4, maximum consecutive B grants while A is pending before A is forced; must be 1 or greater

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
read_a  in  1  instruction-fetch read request, level, held until resp_a
address_a  in  ADDR_WIDTH  fetch address
resp_a  out  1  fetch completion strobe, one cycle
rdata_a  out  DATA_WIDTH  fetch data, valid with resp_a
read_b  in  1  data read request, level, held until resp_b
write_b  in  1  data write request, level, held until resp_b
wmask_b  in  DATA_WIDTH/8  byte-enable for write_b
address_b  in  ADDR_WIDTH  data address
wdata_b  in  DATA_WIDTH  write data
resp_b  out  1  data completion strobe, one cycle
rdata_b  out  DATA_WIDTH  data read result, valid with resp_b
pmem_read  out  1  memory read strobe, registered
pmem_write  out  1  memory write strobe, registered
pmem_wmask  out  DATA_WIDTH/8  registered byte-enable
pmem_address  out  ADDR_WIDTH  registered address
pmem_wdata  out  DATA_WIDTH  registered write data
pmem_rdata  in  DATA_WIDTH  memory read data
pmem_resp  in  1  memory completion, one cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SERVE_A, SERVE_B, and a one-cycle RECOVER state. Reset state is IDLE.
- Reset is asynchronous. It forces IDLE, clears streak_cnt, and drives all pmem_* outputs, resp_a, resp_b and busy to 0. When reset is asserted mid-transaction, the transaction is abandoned and no resp is issued.
- Grant decision is made only in IDLE:
  - B pending (read_b or write_b) and A not pending: grant B.
  - A pending and B not pending: grant A.
  - Both pending: grant B if streak_cnt < MAX_D_STREAK, otherwise grant A.
  - Nothing pending: remain in IDLE.
- At grant, register the granted request into the pmem_* outputs and move to SERVE_A or SERVE_B. Memory therefore sees the strobe one cycle after the IDLE cycle in which the request was sampled.
- An A grant sets pmem_read=1, pmem_write=0, pmem_wmask=0 and pmem_wdata=0.
- If write_b and read_b are both high, the write wins and pmem_read=0.
- streak_cnt:
  - Increments (saturating at MAX_D_STREAK) on a B grant while A is pending.
  - Clears on any A grant.
  - Clears on a B grant while A is not pending.
- SERVE_x: pmem_* are held constant. Requester inputs are ignored, so they may change without effect.
- On pmem_resp in SERVE_x:
  - resp_x = 1 combinationally in the same cycle.
  - rdata_x = pmem_rdata in the same cycle.
  - pmem_read and pmem_write clear on the next edge, and the state moves to RECOVER.
- RECOVER lasts one cycle, then returns to IDLE. This lets the requester drop the satisfied request so it is never re-granted. Minimum request-to-request spacing is 3 cycles plus memory latency.
- rdata_a and rdata_b are 0 except in the cycle their own resp is asserted.
- pmem_resp outside SERVE_x is ignored.
- If a requester withdraws its request during SERVE, the memory transaction still completes and resp is still pulsed.
- busy reflects the registered state.

Test Plan:
- Reset then read_a=1, address_a=0x100, memory responds 2 cycles after the strobe with 0xDEADBEEF -> pmem_read rises 1 cycle after sampling with pmem_address=0x100; resp_a=1 and rdata_a=0xDEADBEEF for exactly one cycle; resp_b never asserted.
- write_b=1, address_b=0x200, wdata_b=0x12345678, wmask_b=4'b0011 -> pmem_write=1, pmem_read=0, pmem_wmask=4'b0011, pmem_wdata=0x12345678; resp_b pulses one cycle; rdata_b=0.
- read_a and read_b held high continuously, with each requester re-asserting after its resp, MAX_D_STREAK=4 -> grant order is B,B,B,B,A,B,B,B,B,A; streak_cnt never exceeds 4.
- read_b and write_b both high in IDLE -> write performed, pmem_read=0 throughout, a single resp_b.
- rst asserted while in SERVE_B before pmem_resp -> pmem_write, busy and resp_b go to 0 immediately, without waiting for a clock edge; a later pmem_resp is ignored; after rst is released, a pending read_a is granted normally.
- pmem_resp pulsed while in IDLE, and address_a changed mid-SERVE_A -> no resp_a or resp_b; pmem_address keeps the originally captured value.
